// File: rtl/disp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : disp_pkg                                                        |
// | Brief    : Shared constants and width check for the display channel adapter|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package disp_pkg;

  localparam logic SYNC_IDLE_DEFAULT = 1'b0;

  // Indexed [y_par][x_par]
  localparam logic [1:0] BAYER2X2 [2][2] = '{'{2'd0, 2'd2}, '{2'd3, 2'd1}};

  function automatic bit widths_ok(input int bpc_in, input int bpc_out, input int chans);
    return (bpc_in >= 1) && (bpc_out >= 1) && (chans >= 1) && (bpc_out <= 4 * bpc_in);
  endfunction

endpackage
`default_nettype wire

// File: rtl/disp_chan_adapt_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : disp_chan_adapt_if                                              |
// | Brief    : Pixel-stream bundle into and out of the channel adapter         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface disp_chan_adapt_if #(
  parameter int CHANS   = 3,
  parameter int BPC_IN  = 5,
  parameter int BPC_OUT = 8
);

  logic                       in_de;
  logic                       in_hsync;
  logic                       in_vsync;
  logic                       in_frame;
  logic [CHANS*BPC_IN-1:0]    in_colr;
  logic                       out_de;
  logic                       out_hsync;
  logic                       out_vsync;
  logic [CHANS*BPC_OUT-1:0]   out_colr;

  modport master (
    output in_de, in_hsync, in_vsync, in_frame, in_colr,
    input  out_de, out_hsync, out_vsync, out_colr
  );

  modport slave (
    input  in_de, in_hsync, in_vsync, in_frame, in_colr,
    output out_de, out_hsync, out_vsync, out_colr
  );

endinterface
`default_nettype wire

// File: rtl/chan_conv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : chan_conv                                                       |
// | Brief    : One colour channel expand/reduce datapath (combinational).      |
// |            DISP_CHAN_ADAPT_DITHER_EN adds 2x2 ordered dither on reduce.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module chan_conv
  import disp_pkg::*;
#(
  parameter int BPC_IN     = 5,
  parameter int BPC_OUT    = 8,
  parameter bit BLANK_ZERO = 1'b1
) (
  input  logic [BPC_IN-1:0]  d,
`ifdef DISP_CHAN_ADAPT_DITHER_EN
  input  logic               x_par,
  input  logic               y_par,
`endif
  input  logic               de,
  output logic [BPC_OUT-1:0] q
);

  logic [BPC_OUT-1:0] conv;

  if (BPC_OUT >= BPC_IN) begin : g_expand
    // Replicate the input MSB-first until the output is full
    always_comb begin
      conv = '0;
      for (int i = 0; i < BPC_OUT; i++) begin
        conv[BPC_OUT-1-i] = d[BPC_IN-1-(i % BPC_IN)];
      end
    end
`ifdef DISP_CHAN_ADAPT_DITHER_EN
    logic unused_par;
    assign unused_par = x_par ^ y_par;
`endif
  end else begin : g_reduce
    localparam int K = BPC_IN - BPC_OUT;
    logic [BPC_IN:0]   t_scaled;
    logic [BPC_IN:0]   sum;
    logic [BPC_IN-1:0] sat;
`ifdef DISP_CHAN_ADAPT_DITHER_EN
    logic [1:0] t;
    assign t = BAYER2X2[y_par][x_par];
    if (K >= 2) begin : g_shl
      assign t_scaled = (BPC_IN+1)'(t) << (K - 2);
    end else begin : g_half
      assign t_scaled = (BPC_IN+1)'(t >> 1);
    end
`else
    assign t_scaled = '0;
`endif
    // Saturate before the shift so bright pixels never wrap to black
    assign sum  = {1'b0, d} + t_scaled;
    assign sat  = sum[BPC_IN] ? '1 : sum[BPC_IN-1:0];
    assign conv = sat[BPC_IN-1:K];
  end

  assign q = (BLANK_ZERO && !de) ? '0 : conv;

endmodule
`default_nettype wire

// File: rtl/disp_chan_adapt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : disp_chan_adapt                                                 |
// | Brief    : Two-stage colour depth adapter with aligned de/sync delay.      |
// |            Define DISP_CHAN_ADAPT_DITHER_EN for ordered dither on reduce.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module disp_chan_adapt
  import disp_pkg::*;
#(
  parameter int   BPC_IN     = 5,
  parameter int   BPC_OUT    = 8,
  parameter int   CHANS      = 3,
  parameter bit   BLANK_ZERO = 1'b1,
  parameter logic SYNC_IDLE  = SYNC_IDLE_DEFAULT
) (
  input logic              clk_pix,
  input logic              rst_pix_n,
  disp_chan_adapt_if.slave bus
);

  if (!widths_ok(BPC_IN, BPC_OUT, CHANS)) begin : g_bad_widths
    $error("disp_chan_adapt: illegal widths BPC_IN=%0d BPC_OUT=%0d CHANS=%0d",
           BPC_IN, BPC_OUT, CHANS);
  end

  logic                     s1_de;
  logic                     s1_hsync;
  logic                     s1_vsync;
  logic [CHANS*BPC_IN-1:0]  s1_colr;
  logic [CHANS*BPC_OUT-1:0] conv_colr;

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      s1_de         <= 1'b0;
      s1_hsync      <= SYNC_IDLE;
      s1_vsync      <= SYNC_IDLE;
      s1_colr       <= '0;
      bus.out_de    <= 1'b0;
      bus.out_hsync <= SYNC_IDLE;
      bus.out_vsync <= SYNC_IDLE;
      bus.out_colr  <= '0;
    end else begin
      s1_de         <= bus.in_de;
      s1_hsync      <= bus.in_hsync;
      s1_vsync      <= bus.in_vsync;
      s1_colr       <= bus.in_colr;
      bus.out_de    <= s1_de;
      bus.out_hsync <= s1_hsync;
      bus.out_vsync <= s1_vsync;
      bus.out_colr  <= conv_colr;
    end
  end

`ifdef DISP_CHAN_ADAPT_DITHER_EN
  logic x_par;
  logic y_par;
  logic y_par_nxt;
  logic s1_x;
  logic s1_y;

  // Frame start wins over a coincident end-of-line toggle
  always_comb begin
    y_par_nxt = y_par;
    if (bus.in_frame) begin
      y_par_nxt = 1'b0;
    end else if (s1_de && !bus.in_de) begin
      y_par_nxt = ~y_par;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      x_par <= 1'b0;
      y_par <= 1'b0;
      s1_x  <= 1'b0;
      s1_y  <= 1'b0;
    end else begin
      x_par <= bus.in_de ? ~x_par : 1'b0;
      y_par <= y_par_nxt;
      s1_x  <= x_par;
      s1_y  <= y_par_nxt;
    end
  end
`else
  logic unused_frame;
  assign unused_frame = bus.in_frame;
`endif

  for (genvar c = 0; c < CHANS; c++) begin : g_chan
    chan_conv #(
      .BPC_IN     (BPC_IN),
      .BPC_OUT    (BPC_OUT),
      .BLANK_ZERO (BLANK_ZERO)
    ) u_conv (
      .d     (s1_colr[c*BPC_IN +: BPC_IN]),
`ifdef DISP_CHAN_ADAPT_DITHER_EN
      .x_par (s1_x),
      .y_par (s1_y),
`endif
      .de    (s1_de),
      .q     (conv_colr[c*BPC_OUT +: BPC_OUT])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_disp_chan_adapt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_disp_chan_adapt                                              |
// | Brief    : Directed bench: 5->8 blank/pass-through and 8->5 instances;     |
// |            dither sequence active when DISP_CHAN_ADAPT_DITHER_EN defined.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_disp_chan_adapt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  disp_chan_adapt_if #(.CHANS(3), .BPC_IN(5), .BPC_OUT(8)) ia ();
  disp_chan_adapt_if #(.CHANS(3), .BPC_IN(5), .BPC_OUT(8)) ib ();
  disp_chan_adapt_if #(.CHANS(3), .BPC_IN(8), .BPC_OUT(5)) ic ();

  disp_chan_adapt #(.BPC_IN(5), .BPC_OUT(8), .CHANS(3), .BLANK_ZERO(1'b1), .SYNC_IDLE(1'b0))
    dut_a (.clk_pix(clk), .rst_pix_n(rst_n), .bus(ia));
  disp_chan_adapt #(.BPC_IN(5), .BPC_OUT(8), .CHANS(3), .BLANK_ZERO(1'b0), .SYNC_IDLE(1'b1))
    dut_b (.clk_pix(clk), .rst_pix_n(rst_n), .bus(ib));
  disp_chan_adapt #(.BPC_IN(8), .BPC_OUT(5), .CHANS(3), .BLANK_ZERO(1'b1), .SYNC_IDLE(1'b0))
    dut_c (.clk_pix(clk), .rst_pix_n(rst_n), .bus(ic));

  typedef struct {
    logic        de;
    logic        hs;
    logic        vs;
    logic [14:0] c5;
    logic [23:0] c8;
    logic [23:0] ea;
    logic [23:0] eb;
    logic [14:0] ec;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  logic       have_prev;
  logic       prev_de;
  logic [4:0] prev_exp;
  int         step_no;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ia.in_de = v.de; ia.in_hsync = v.hs; ia.in_vsync = v.vs; ia.in_frame = 1'b0; ia.in_colr = v.c5;
    ib.in_de = v.de; ib.in_hsync = v.hs; ib.in_vsync = v.vs; ib.in_frame = 1'b0; ib.in_colr = v.c5;
    ic.in_de = v.de; ic.in_hsync = v.hs; ic.in_vsync = v.vs; ic.in_frame = 1'b0; ic.in_colr = v.c8;
  endtask

  // Output seen after each edge belongs to the previous step's input
  task automatic step_c(input logic de, input logic frame, input logic [7:0] d, input logic [4:0] e);
    ic.in_de = de; ic.in_frame = frame; ic.in_colr = {3{d}};
    ic.in_hsync = 1'b0; ic.in_vsync = 1'b0;
    @(posedge clk); #1;
    if (have_prev) begin
      chk($sformatf("seq%0d c_de", step_no), 32'(ic.out_de), 32'(prev_de));
      chk($sformatf("seq%0d c_colr", step_no), 32'(ic.out_colr), 32'({3{prev_exp}}));
    end
    have_prev = 1'b1;
    prev_de   = de;
    prev_exp  = de ? e : 5'h00;
    step_no++;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, {5'h01, 5'h10, 5'h1F}, {8'h00, 8'h87, 8'hFF},
                {8'h08, 8'h84, 8'hFF}, {8'h08, 8'h84, 8'hFF}, {5'h00, 5'h10, 5'h1F}};
    vecs[1] = '{1'b0, 1'b0, 1'b1, {3{5'h1F}}, {3{8'hFF}},
                24'h0, {3{8'hFF}}, 15'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, {5'h0A, 5'h1F, 5'h00}, {8'h80, 8'h7F, 8'h08},
                {8'h52, 8'hFF, 8'h00}, {8'h52, 8'hFF, 8'h00}, {5'h10, 5'h0F, 5'h01}};
    vecs[3] = '{1'b1, 1'b1, 1'b1, {5'h1E, 5'h03, 5'h15}, {8'hF8, 8'h0F, 8'h01},
                {8'hF7, 8'h18, 8'hAD}, {8'hF7, 8'h18, 8'hAD}, {5'h1F, 5'h01, 5'h00}};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 15'h0, 24'h0, 24'h0, 24'h0, 15'h0};

    // Reset with active inputs: outputs must hold reset values
    drive(vecs[3]);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst a_ctl", 32'({ia.out_de, ia.out_hsync, ia.out_vsync}), 32'(3'b000));
    chk("rst a_colr", 32'(ia.out_colr), 32'h0);
    chk("rst b_ctl", 32'({ib.out_de, ib.out_hsync, ib.out_vsync}), 32'(3'b011));
    chk("rst b_colr", 32'(ib.out_colr), 32'h0);
    chk("rst c_ctl", 32'({ic.out_de, ic.out_hsync, ic.out_vsync}), 32'(3'b000));
    chk("rst c_colr", 32'(ic.out_colr), 32'h0);
    rst_n = 1'b1;
    drive(vecs[4]);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i <= NV; i++) begin
      drive(vecs[(i < NV) ? i : NV-1]);
      @(posedge clk); #1;
      if (i >= 1) begin
        chk($sformatf("vec%0d a_ctl", i-1), 32'({ia.out_de, ia.out_hsync, ia.out_vsync}),
            32'({vecs[i-1].de, vecs[i-1].hs, vecs[i-1].vs}));
        chk($sformatf("vec%0d a_colr", i-1), 32'(ia.out_colr), 32'(vecs[i-1].ea));
        chk($sformatf("vec%0d b_ctl", i-1), 32'({ib.out_de, ib.out_hsync, ib.out_vsync}),
            32'({vecs[i-1].de, vecs[i-1].hs, vecs[i-1].vs}));
        chk($sformatf("vec%0d b_colr", i-1), 32'(ib.out_colr), 32'(vecs[i-1].eb));
`ifndef DISP_CHAN_ADAPT_DITHER_EN
        chk($sformatf("vec%0d c_colr", i-1), 32'(ic.out_colr), 32'(vecs[i-1].ec));
`endif
      end
    end

    // Mid-line reset then restart
    repeat (3) begin
      drive(vecs[0]);
      @(posedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst a_ctl", 32'({ia.out_de, ia.out_hsync, ia.out_vsync}), 32'(3'b000));
    chk("midrst a_colr", 32'(ia.out_colr), 32'h0);
    chk("midrst b_ctl", 32'({ib.out_de, ib.out_hsync, ib.out_vsync}), 32'(3'b011));
    chk("midrst c_colr", 32'(ic.out_colr), 32'h0);
    rst_n = 1'b1;
    drive(vecs[2]);
    @(posedge clk); #1;
    chk("restart1 a_ctl", 32'({ia.out_de, ia.out_hsync, ia.out_vsync}), 32'(3'b000));
    chk("restart1 a_colr", 32'(ia.out_colr), 32'h0);
    drive(vecs[4]);
    @(posedge clk); #1;
    chk("restart2 a_ctl", 32'({ia.out_de, ia.out_hsync, ia.out_vsync}), 32'(3'b100));
    chk("restart2 a_colr", 32'(ia.out_colr), 32'(vecs[2].ea));
    @(posedge clk); #1;

    have_prev = 1'b0;
    step_no   = 0;
`ifdef DISP_CHAN_ADAPT_DITHER_EN
    step_c(1'b0, 1'b1, 8'h00, 5'h00);
    step_c(1'b1, 1'b0, 8'h85, 5'h10);
    step_c(1'b1, 1'b0, 8'h85, 5'h11);
    step_c(1'b0, 1'b0, 8'h00, 5'h00);
    step_c(1'b1, 1'b0, 8'h85, 5'h11);
    step_c(1'b1, 1'b0, 8'h85, 5'h10);
    step_c(1'b0, 1'b1, 8'h00, 5'h00);
    step_c(1'b1, 1'b0, 8'h85, 5'h10);
    step_c(1'b1, 1'b0, 8'h85, 5'h11);
    step_c(1'b1, 1'b0, 8'h85, 5'h10);
    step_c(1'b0, 1'b0, 8'h00, 5'h00);
    step_c(1'b1, 1'b0, 8'h85, 5'h11);
    step_c(1'b1, 1'b0, 8'hFE, 5'h1F);
    step_c(1'b0, 1'b1, 8'h00, 5'h00);
    step_c(1'b1, 1'b0, 8'hFE, 5'h1F);
    step_c(1'b1, 1'b0, 8'hFE, 5'h1F);
`else
    step_c(1'b0, 1'b1, 8'h00, 5'h00);
    step_c(1'b1, 1'b0, 8'h85, 5'h10);
    step_c(1'b1, 1'b0, 8'h85, 5'h10);
    step_c(1'b1, 1'b0, 8'hFE, 5'h1F);
    step_c(1'b1, 1'b0, 8'h07, 5'h00);
`endif
    step_c(1'b0, 1'b0, 8'h00, 5'h00);
    step_c(1'b0, 1'b0, 8'h00, 5'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disp_chan_adapt.md
Name: disp_chan_adapt

Overview:
Pipelined display colour-channel adapter between the chapter display core and the TMDS/DVI encoder.
- Converts CHANS colour channels from BPC_IN to BPC_OUT bits per channel, either expanding or reducing.
- Delays de/hsync/vsync to stay aligned with colour.
- Optionally blanks colour outside the active area and applies 2x2 ordered dithering when reducing.
- Replaces the ad-hoc combinational 5-to-8 widening in board tops with one registered, parametrised block.

Parameters:
- BPC_IN, 5, input bits per channel (>=1).
- BPC_OUT, 8, output bits per channel (>=1, <=4*BPC_IN).
- CHANS, 3, number of colour channels; channel 0 in LSBs of packed buses.
- BLANK_ZERO, 1, 1 = force colour to 0 when de is low; 0 = pass through.
- SYNC_IDLE, 1'b0, reset/idle value driven on out_hsync and out_vsync.

Ports:
- clk_pix  in  1  pixel clock; all logic in this domain.
- rst_pix_n  in  1  synchronous, active-low reset.
- in_de  in  1  data enable.
- in_hsync  in  1  horizontal sync, passed through unmodified.
- in_vsync  in  1  vertical sync, passed through unmodified.
- in_frame  in  1  single-cycle start-of-frame pulse.
- in_colr  in  CHANS*BPC_IN  packed input colour.
- out_de  out  1  delayed de.
- out_hsync  out  1  delayed hsync.
- out_vsync  out  1  delayed vsync.
- out_colr  out  CHANS*BPC_OUT  packed converted colour.

Behaviour:
- Reset: clock clk_pix; reset rst_pix_n is synchronous, active-low. When rst_pix_n=0 at a clock edge:
  - out_de=0, out_colr=0, out_hsync=out_vsync=SYNC_IDLE.
  - All pipeline registers and dither parity counters clear.
  - Reset mid-line simply restarts; no partial state survives.
- Latency: fixed 2 clk_pix cycles, input to output, for colour, de and both syncs. Sample N appears on outputs at edge N+2. Throughput: one pixel per cycle, no stalls.
- Stage 1: register inputs; update dither parity.
- Stage 2: per-channel conversion; register outputs.
- Expand (BPC_OUT >= BPC_IN):
  - Output = input bits repeated MSB-first, concatenated, truncated to BPC_OUT.
  - 5->8: {d, d[4:2]}; 4->8: {d, d}; 2->5: {d, d, d[1]}.
  - Equal widths: identity.
- Reduce (BPC_OUT < BPC_IN), dither disabled: k = BPC_IN-BPC_OUT; output = d >> k (truncate).
- Blanking: if BLANK_ZERO=1 and the stage-1 de = 0, out_colr = 0 regardless of input. Syncs are never altered.
- Dither parity counters (stage 1):
  - x_par toggles each cycle in_de=1; cleared when in_de=0.
  - y_par toggles on each in_de falling edge.
  - in_frame=1 clears y_par; this takes priority over a simultaneous de falling edge.
- Widths: all arithmetic unsigned. Intermediate sum is BPC_IN+1 bits; saturate before shift so output never wraps.

Optional Feature:
- Macro: DISP_CHAN_ADAPT_DITHER_EN.
- Defined, and reducing:
  - Threshold t = Bayer2x2[y_par][x_par] = {0,2; 3,1}.
  - Scaled: t << (k-2) for k>=2, t >> 1 for k=1.
  - Output = min(d + t_scaled, 2^BPC_IN - 1) >> k.
- Defined, expanding: no effect.
- Undefined: no counters synthesised; plain truncation. Latency unchanged in both builds.

Decomposition:
- Package disp_pkg: Bayer 2x2 threshold constant, SYNC_IDLE default, and a width-checking function (elaboration error if BPC_OUT > 4*BPC_IN or any width is 0).
- Sub-module chan_conv: one channel's expand/reduce/dither datapath, stage-2 combinational. Instantiated CHANS times by generate.
- Top owns pipeline registers and parity counters.

Test Plan:
- 5->8 expand, CHANS=3: in_colr R=5'h1F, G=5'h10, B=5'h01, de=1 → after 2 cycles R=8'hFF, G=8'h84, B=8'h08; syncs track with 2-cycle delay.
- Blanking, BLANK_ZERO=1: in_colr all 5'h1F, de=0 → out_colr=0. With BLANK_ZERO=0 → 8'hFF each.
- Reset: assert rst_pix_n=0 mid-line with data flowing → next edge out_de=0, out_colr=0, syncs=SYNC_IDLE. Release → first valid output 2 cycles after the first new input.
- Reduce 8->5, macro undefined: d=8'hFF → 5'h1F; d=8'h87 → 5'h10.
- Reduce 8->5, DITHER_EN defined, constant d=8'h85, k=3, 2x2 pixels at frame start:
  - Thresholds 0,4,6,2 → outputs 5'h10, 5'h11, 5'h11, 5'h10.
  - d=8'hFE saturates at 5'h1F, never 0.
- Parity: in_frame pulse coincident with de falling → y_par=0 on next line; x_par restarts at 0 each line.
